// File: rtl/rtc_pkg.sv
// Shared widths, limits and types for the rtc_timekeeper slice.
package rtc_pkg;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HR_W    = 5;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  typedef enum logic {IDLE, LOAD} rtc_state_t;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } rtc_time_t;
endpackage

// File: rtl/rtc_mod_counter.sv
// Modulo-MOD counter with enable, synchronous load (load wins) and carry-out.
module rtc_mod_counter #(
  parameter int unsigned MOD = 60,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] nxt_o,
  output logic         carry_o
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         at_max;

  assign at_max = (cnt_q == W'(MOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = ld_val_i;
    else if (en_i)
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q_o     = cnt_q;
  assign nxt_o   = cnt_d;
  assign carry_o = en_i && !ld_i && at_max;
endmodule

// File: rtl/rtc_timekeeper.sv
// Hours/minutes/seconds timekeeper with prescaler, run gate and validated time load.
// Optional alarm comparator enabled by defining RTC_TIMEKEEPER_ALARM_EN.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 1,
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             set_valid,
  output logic             set_ready,
  input  logic [HR_W-1:0]  set_hr,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  output logic             set_err,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             sec_pulse,
  output logic             min_pulse,
  output logic             day_pulse,
  input  logic             alarm_en,
  input  logic [HR_W-1:0]  alarm_hr,
  input  logic [MIN_W-1:0] alarm_min,
  output logic             alarm_fire
);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  rtc_state_t       state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  rtc_time_t        shadow_q, shadow_d;
  logic             accept, load_ok, commit, tick;
  logic             sec_co, min_co, hr_co;
  logic             sec_pulse_q, min_pulse_q, day_pulse_q, set_err_q;
  logic [SEC_W-1:0] sec_nxt;
  logic [MIN_W-1:0] min_nxt;
  logic [HR_W-1:0]  hr_nxt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    set_ready = (state_q == IDLE);
  end

  assign accept  = set_valid && set_ready;
  assign load_ok = (shadow_q.sec <= SEC_W'(SEC_MAX)) && (shadow_q.min <= MIN_W'(MIN_MAX)) &&
                   ({1'b0, shadow_q.hr} < (HR_W+1)'(HOURS_PER_DAY));
  assign commit  = (state_q == LOAD) && load_ok;
  // Ticks only exist in IDLE, so the LOAD cycle drops any due tick and the prescaler holds.
  assign tick    = run && (state_q == IDLE) && (pre_q == PW'(CLK_DIV - 1));

  always_comb begin
    pre_d = pre_q;
    if (commit)
      pre_d = '0;
    else if (run && state_q == IDLE)
      pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    shadow_d = shadow_q;
    if (accept) shadow_d = '{hr: set_hr, min: set_min, sec: set_sec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= '0;
      shadow_q    <= '0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      shadow_q    <= shadow_d;
      sec_pulse_q <= tick;
      min_pulse_q <= sec_co;
      day_pulse_q <= hr_co;
      set_err_q   <= (state_q == LOAD) && !load_ok;
    end
  end

  rtc_mod_counter #(.MOD(SEC_MAX + 1), .W(SEC_W)) u_sec (
    .clk(clk), .rst(rst), .en_i(tick), .ld_i(commit), .ld_val_i(shadow_q.sec),
    .q_o(sec), .nxt_o(sec_nxt), .carry_o(sec_co)
  );

  rtc_mod_counter #(.MOD(MIN_MAX + 1), .W(MIN_W)) u_min (
    .clk(clk), .rst(rst), .en_i(sec_co), .ld_i(commit), .ld_val_i(shadow_q.min),
    .q_o(min), .nxt_o(min_nxt), .carry_o(min_co)
  );

  rtc_mod_counter #(.MOD(HOURS_PER_DAY), .W(HR_W)) u_hr (
    .clk(clk), .rst(rst), .en_i(min_co), .ld_i(commit), .ld_val_i(shadow_q.hr),
    .q_o(hr), .nxt_o(hr_nxt), .carry_o(hr_co)
  );

  assign sec_pulse = sec_pulse_q;
  assign min_pulse = min_pulse_q;
  assign day_pulse = day_pulse_q;
  assign set_err   = set_err_q;

`ifdef RTC_TIMEKEEPER_ALARM_EN
  logic alarm_q;
  logic unused_nxt;

  // sec_co marks a tick-driven minute rollover; commits never raise it.
  always_ff @(posedge clk) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= sec_co && alarm_en && (hr_nxt == alarm_hr) && (min_nxt == alarm_min);
  end

  assign alarm_fire = alarm_q;
  assign unused_nxt = ^sec_nxt;
`else
  logic unused_alarm;

  assign alarm_fire   = 1'b0;
  assign unused_alarm = ^{alarm_en, alarm_hr, alarm_min, hr_nxt, min_nxt, sec_nxt};
`endif
endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench: two instances (CLK_DIV=1 and 4) checked every cycle against a seconds-of-day model.
module tb_rtc_timekeeper;
`ifdef RTC_TIMEKEEPER_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif
  localparam int DAY = 24 * 3600;

  logic       clk = 1'b0;
  logic       rst, run, set_valid, alarm_en;
  logic [4:0] set_hr, alarm_hr;
  logic [5:0] set_min, set_sec, alarm_min;

  logic       o_rdy[2], o_err[2], o_sp[2], o_mp[2], o_dp[2], o_al[2];
  logic [4:0] o_hr[2];
  logic [5:0] o_min[2], o_sec[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtc_timekeeper #(.CLK_DIV(1), .HOURS_PER_DAY(24)) u_div1 (
    .clk(clk), .rst(rst), .run(run), .set_valid(set_valid), .set_ready(o_rdy[0]),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_err(o_err[0]),
    .hr(o_hr[0]), .min(o_min[0]), .sec(o_sec[0]),
    .sec_pulse(o_sp[0]), .min_pulse(o_mp[0]), .day_pulse(o_dp[0]),
    .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_fire(o_al[0])
  );

  rtc_timekeeper #(.CLK_DIV(4), .HOURS_PER_DAY(24)) u_div4 (
    .clk(clk), .rst(rst), .run(run), .set_valid(set_valid), .set_ready(o_rdy[1]),
    .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_err(o_err[1]),
    .hr(o_hr[1]), .min(o_min[1]), .sec(o_sec[1]),
    .sec_pulse(o_sp[1]), .min_pulse(o_mp[1]), .day_pulse(o_dp[1]),
    .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_fire(o_al[1])
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: time as seconds-of-day, prescaler phase, pending-load flag.
  int  divs[2] = '{1, 4};
  int  tod[2], ph[2], sh_h[2], sh_m[2], sh_s[2];
  bit  pend[2], e_sp[2], e_mp[2], e_dp[2], e_err[2], e_al[2];
  bit  mvalid = 1'b0;

  function automatic void model_step(int i);
    e_sp[i] = 0; e_mp[i] = 0; e_dp[i] = 0; e_err[i] = 0; e_al[i] = 0;
    if (rst) begin
      tod[i] = 0; ph[i] = 0; pend[i] = 0; sh_h[i] = 0; sh_m[i] = 0; sh_s[i] = 0;
    end else if (pend[i]) begin
      pend[i] = 0;
      if (sh_s[i] <= 59 && sh_m[i] <= 59 && sh_h[i] < 24) begin
        tod[i] = sh_h[i] * 3600 + sh_m[i] * 60 + sh_s[i];
        ph[i]  = 0;
      end else begin
        e_err[i] = 1;
      end
    end else begin
      if (run) begin
        if (ph[i] == divs[i] - 1) begin
          ph[i]   = 0;
          tod[i]  = (tod[i] + 1) % DAY;
          e_sp[i] = 1;
          e_mp[i] = (tod[i] % 60 == 0);
          e_dp[i] = (tod[i] == 0);
          e_al[i] = ALARM && e_mp[i] && alarm_en &&
                    (tod[i] == int'(alarm_hr) * 3600 + int'(alarm_min) * 60);
        end else begin
          ph[i] = ph[i] + 1;
        end
      end
      if (set_valid) begin
        pend[i] = 1;
        sh_h[i] = int'(set_hr); sh_m[i] = int'(set_min); sh_s[i] = int'(set_sec);
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("u%0d.hr", i),        o_hr[i],  tod[i] / 3600);
        cmp($sformatf("u%0d.min", i),       o_min[i], (tod[i] / 60) % 60);
        cmp($sformatf("u%0d.sec", i),       o_sec[i], tod[i] % 60);
        cmp($sformatf("u%0d.set_ready", i), o_rdy[i], !pend[i]);
        cmp($sformatf("u%0d.set_err", i),   o_err[i], e_err[i]);
        cmp($sformatf("u%0d.sec_pulse", i), o_sp[i],  e_sp[i]);
        cmp($sformatf("u%0d.min_pulse", i), o_mp[i],  e_mp[i]);
        cmp($sformatf("u%0d.day_pulse", i), o_dp[i],  e_dp[i]);
        cmp($sformatf("u%0d.alarm_fire", i), o_al[i], e_al[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hms(input string nm, input int i, input int h, input int m, input int s);
    cmp({nm, ".hr"},  o_hr[i],  h);
    cmp({nm, ".min"}, o_min[i], m);
    cmp({nm, ".sec"}, o_sec[i], s);
  endtask

  task automatic load(input int h, input int m, input int s);
    set_valid = 1'b1;
    set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    step(1);
    cmp("lit_ready_low_in_load", o_rdy[0], 0);
    set_valid = 1'b0;
    step(1);
  endtask

  int nsp, nmp;

  initial begin
    rst = 1'b1; run = 1'b0; set_valid = 1'b0; alarm_en = 1'b0;
    set_hr = '0; set_min = '0; set_sec = '0; alarm_hr = '0; alarm_min = '0;
    step(2);
    hms("lit_reset", 0, 0, 0, 0);
    cmp("lit_reset_ready", o_rdy[0], 1);
    cmp("lit_reset_pulse", o_sp[0], 0);

    rst = 1'b0; run = 1'b1;
    nsp = 0; nmp = 0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (o_sp[0]) nsp++;
      if (o_mp[0]) nmp++;
    end
    hms("lit_200cyc_div1", 0, 0, 3, 20);
    cmp("lit_200cyc_div4_sec", o_sec[1], 50);
    cmp("lit_sec_pulses", nsp, 200);
    cmp("lit_min_pulses", nmp, 3);

    load(23, 59, 58);
    hms("lit_commit_235958", 0, 23, 59, 58);
    cmp("lit_commit_no_sec_pulse", o_sp[0], 0);
    cmp("lit_ready_back", o_rdy[0], 1);
    step(1);
    hms("lit_235959", 0, 23, 59, 59);
    cmp("lit_no_early_min_pulse", o_mp[0], 0);
    step(1);
    hms("lit_midnight", 0, 0, 0, 0);
    cmp("lit_midnight_min_pulse", o_mp[0], 1);
    cmp("lit_midnight_day_pulse", o_dp[0], 1);

    run = 1'b0;
    step(10);
    cmp("lit_frozen_div1_sec", o_sec[0], 0);
    cmp("lit_frozen_div4_sec", o_sec[1], 58);
    run = 1'b1;
    step(1);
    cmp("lit_resume1_div4_sec", o_sec[1], 58);
    step(1);
    cmp("lit_resume2_div4_sec", o_sec[1], 59);
    cmp("lit_resume2_div4_pulse", o_sp[1], 1);

    step(3);
    hms("lit_at_000005", 0, 0, 0, 5);
    load(0, 60, 0);
    cmp("lit_bad_load_err", o_err[0], 1);
    hms("lit_bad_load_time", 0, 0, 0, 6);
    step(1);
    cmp("lit_bad_load_err_once", o_err[0], 0);
    cmp("lit_bad_load_next_sec", o_sec[0], 7);

    load(5, 10, 0);
    hms("lit_commit_051000", 0, 5, 10, 0);
    cmp("lit_commit_no_min_pulse", o_mp[0], 0);
    cmp("lit_commit_no_sec_pulse2", o_sp[0], 0);
    cmp("lit_commit_ready", o_rdy[0], 1);
    step(1);
    cmp("lit_after_commit_sec", o_sec[0], 1);

    alarm_en = 1'b1; alarm_hr = 5'd0; alarm_min = 6'd2;
    load(0, 1, 58);
    step(2);
    hms("lit_alarm_time", 0, 0, 2, 0);
    cmp("lit_alarm_min_pulse", o_mp[0], 1);
    cmp("lit_alarm_fire", o_al[0], ALARM ? 1 : 0);
    load(0, 2, 0);
    cmp("lit_alarm_commit_no_fire", o_al[0], 0);
    step(1);
    cmp("lit_alarm_after_commit", o_al[0], 0);

    set_valid = 1'b1; set_hr = 5'd1; set_min = 6'd1; set_sec = 6'd1;
    step(1);
    set_valid = 1'b0; rst = 1'b1;
    step(1);
    hms("lit_reset_over_load", 0, 0, 0, 0);
    cmp("lit_reset_over_load_ready", o_rdy[0], 1);
    rst = 1'b0;
    step(1);
    cmp("lit_after_reset_sec", o_sec[0], 1);
    step(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
- Parametrised hours/minutes/seconds timekeeper. Successor to the free-running min/sec digital_clock.
- Adds a clock prescaler, a configurable hour rollover, a run gate, and a validated time-set handshake.
- Provides rollover pulses for downstream display and event logic.
- Sits between the system clock domain and display/alarm consumers. Single clock domain.

Parameters:
- CLK_DIV, default 1: clk cycles per one-second tick. Range 1..2^24. A value of 1 gives one tick per cycle, matching the legacy clock.
- HOURS_PER_DAY, default 24: hour counter modulus. Range 1..32.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  counting enable; when low, prescaler and counters hold
- set_valid  in  1  time-load request
- set_ready  out  1  load can be accepted
- set_hr  in  5  hour to load
- set_min  in  6  minute to load
- set_sec  in  6  second to load
- set_err  out  1  one-cycle pulse: last accepted load was out of range and was discarded
- hr  out  5  current hour
- min  out  6  current minute
- sec  out  6  current second
- sec_pulse  out  1  one-cycle pulse on each second increment
- min_pulse  out  1  one-cycle pulse when sec wraps 59->0
- day_pulse  out  1  one-cycle pulse when hr wraps HOURS_PER_DAY-1 -> 0
- alarm_en  in  1  alarm arm (ALARM_EN only)
- alarm_hr  in  5  alarm hour (ALARM_EN only)
- alarm_min  in  6  alarm minute (ALARM_EN only)
- alarm_fire  out  1  one-cycle alarm pulse

Behaviour:
- Reset: all outputs are 0 except set_ready=1. Prescaler=0, FSM=IDLE, shadow registers=0. Reset overrides every other event, including a load in flight.
- Prescaler: counts 0..CLK_DIV-1 while run=1 and FSM=IDLE. A tick occurs in the cycle where count==CLK_DIV-1; count then wraps to 0. It holds when run=0.
- Tick effects: sec++. At sec==59, sec goes to 0 and min++. At min==59 with that carry, min goes to 0 and hr++. At hr==HOURS_PER_DAY-1 with that carry, hr goes to 0.
- Latency: new counter values and the matching pulses are registered. They are visible in the cycle after the tick cycle, together.
- FSM states: IDLE and LOAD.
  - IDLE: set_ready=1. On set_valid&&set_ready, capture set_* into shadow registers and go to LOAD.
  - LOAD: set_ready=0 for exactly one cycle. Counting is paused; any tick due in this cycle is dropped and the prescaler holds.
  - LOAD, valid data (sec<=59, min<=59, hr<HOURS_PER_DAY): commit shadow values to hr/min/sec next cycle and clear the prescaler to 0.
  - LOAD, invalid data: time is unchanged and set_err pulses next cycle.
  - LOAD always returns to IDLE.
- Simultaneous acceptance and tick in IDLE: the tick is applied and the load captured. The LOAD commit then overwrites the time.
- A commit never generates sec_pulse, min_pulse or day_pulse.
- Width rules: comparisons are unsigned. Overflow is impossible given the wrap rules.

Optional Feature:
- Macro: RTC_TIMEKEEPER_ALARM_EN.
- Defined: alarm_fire pulses one cycle, aligned with min_pulse, when a tick-driven minute rollover produces hr==alarm_hr and min==alarm_min (sec==0) with alarm_en=1. A commit landing on the alarm time does not fire.
- Undefined: alarm ports remain present, inputs are ignored, and alarm_fire is tied to 0.

Decomposition:
- Package rtc_pkg holds:
  - localparams SEC_W=6, MIN_W=6, HR_W=5, SEC_MAX=59, MIN_MAX=59
  - typedef enum logic {IDLE, LOAD} rtc_state_t
  - packed struct rtc_time_t {hr, min, sec}
- Sub-module rtc_mod_counter: generic modulo-N counter with enable, load and carry-out. Instantiated three times for sec, min and hr. The prescaler is inline.

Test Plan:
- CLK_DIV=1, HOURS_PER_DAY=24: rst high 2 cycles, run=1 for 200 cycles -> hr=0, min=3, sec=20. sec_pulse every cycle. min_pulse exactly 3 times.
- Load 23:59:58, run 2 ticks -> 23:59:59 then 00:00:00. min_pulse and day_pulse each assert once, on the same cycle.
- Load min=60 while at 00:00:05 -> set_ready low 1 cycle, set_err pulses once, time stays 00:00:05 plus normal ticks.
- CLK_DIV=4: sec increments every 4th cycle. Drop run for 10 cycles mid-count -> sec frozen, and the phase resumes where it stopped.
- set_valid held with run=1 -> load accepted, the LOAD cycle drops a tick, committed value 05:10:00 appears exactly, no pulses on commit. set_ready returns high the following cycle.
- RTC_TIMEKEEPER_ALARM_EN: alarm 00:02, alarm_en=1, load 00:01:58, run 2 ticks -> alarm_fire with min_pulse. Loading 00:02:00 directly gives no fire. Without the macro, alarm_fire stays 0.
